// File: rtl/traffic_pkg.sv
// Shared definitions for the adaptive traffic-phase controller.
//   phase_state_e  : controller phase (GREEN -> YELLOW -> ALLRED -> GREEN)
//   dir_sum_width  : width of a per-direction lane-count sum, wide enough
//                    that adding LANES_PER_DIR counts of COUNT_W bits never
//                    overflows.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN,
    YELLOW,
    ALLRED
  } phase_state_e;

  function automatic int unsigned dir_sum_width(input int unsigned count_w,
                                                input int unsigned lanes);
    return count_w + $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/adaptive_phase_controller_dir_argmax.sv
// dir_argmax: combinational argmax over NUM_DIR packed sums, skipping the
// direction given by exclude. Ties resolve to the lowest index.
//   sums    in  NUM_DIR*SUM_W  sum of direction d at slice d*SUM_W +: SUM_W
//   exclude in  DIR_W          direction not eligible to win
//   win_idx out DIR_W          winning direction
//   win_sum out SUM_W          sum of the winning direction
module dir_argmax #(
  parameter int unsigned NUM_DIR = 4,
  parameter int unsigned SUM_W   = 10,
  parameter int unsigned DIR_W   = 2
) (
  input  logic [NUM_DIR*SUM_W-1:0] sums,
  input  logic [DIR_W-1:0]         exclude,
  output logic [DIR_W-1:0]         win_idx,
  output logic [SUM_W-1:0]         win_sum
);

  logic found;

  always_comb begin
    win_idx = '0;
    win_sum = '0;
    found   = 1'b0;
    // Strict '>' keeps the earliest (lowest-index) direction on a tie.
    for (int unsigned d = 0; d < NUM_DIR; d++) begin
      if ((DIR_W'(d) != exclude) &&
          (!found || (sums[d*SUM_W +: SUM_W] > win_sum))) begin
        found   = 1'b1;
        win_idx = DIR_W'(d);
        win_sum = sums[d*SUM_W +: SUM_W];
      end
    end
  end

endmodule

// File: rtl/adaptive_phase_controller.sv
// adaptive_phase_controller: grants right of way to one approach direction at
// a time, moving it to the busiest other direction after a minimum green,
// through a yellow and a one-cycle all-red clearance.
//   clk, rst_n    clock, asynchronous active-low reset
//   en            advance enable; low freezes every register
//   lane_count    per-lane car counts, lane l of dir d at (d*LANES_PER_DIR+l)*COUNT_W
//   green/yellow  per-lane lights, bit d*LANES_PER_DIR+l
//   phase_dir     direction holding right of way
//   phase_change  pulse on the first green cycle of a new direction
// Optional: `define STARVATION_GUARD_EN adds per-direction wait counters that
// force service of a direction waiting MAX_WAIT cycles.
module adaptive_phase_controller
  import traffic_pkg::*;
#(
  parameter  int unsigned NUM_DIR       = 4,
  parameter  int unsigned LANES_PER_DIR = 2,
  parameter  int unsigned COUNT_W       = 8,
  parameter  int unsigned MIN_GREEN     = 8,
  parameter  int unsigned YELLOW_CYC    = 3,
  parameter  int unsigned MAX_WAIT      = 32,
  localparam int unsigned DIR_W         = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic [NUM_DIR*LANES_PER_DIR*COUNT_W-1:0] lane_count,
  output logic [NUM_DIR*LANES_PER_DIR-1:0]     green,
  output logic [NUM_DIR*LANES_PER_DIR-1:0]     yellow,
  output logic [DIR_W-1:0]                     phase_dir,
  output logic                                 phase_change
);

  localparam int unsigned SUM_W   = dir_sum_width(COUNT_W, LANES_PER_DIR);
  localparam int unsigned LANES_W = NUM_DIR * LANES_PER_DIR;
  localparam int unsigned TMAX    = (MIN_GREEN > YELLOW_CYC) ? MIN_GREEN : YELLOW_CYC;
  localparam int unsigned TMR_W   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [LANES_W-1:0] DIR_MASK = LANES_W'({LANES_PER_DIR{1'b1}});

  if (NUM_DIR < 2 || MIN_GREEN < 1 || YELLOW_CYC < 1 || MAX_WAIT < 1) begin : g_param_check
    $error("adaptive_phase_controller: illegal parameter value");
  end

  phase_state_e            state, state_n;
  logic [TMR_W-1:0]        timer, timer_n;
  logic [DIR_W-1:0]        next_dir, next_dir_n, dir_n;
  logic [LANES_W-1:0]      green_n, yellow_n;
  logic                    pc_n;
  logic [NUM_DIR*SUM_W-1:0] sums;
  logic [SUM_W-1:0]        acc, cur_sum, arg_sum;
  logic [DIR_W-1:0]        arg_idx, cand_idx;
  logic                    do_switch;

  always_comb begin
    sums = '0;
    acc  = '0;
    for (int unsigned d = 0; d < NUM_DIR; d++) begin
      acc = '0;
      for (int unsigned l = 0; l < LANES_PER_DIR; l++)
        acc = acc + SUM_W'(lane_count[(d*LANES_PER_DIR+l)*COUNT_W +: COUNT_W]);
      sums[d*SUM_W +: SUM_W] = acc;
    end
  end

  assign cur_sum = sums[phase_dir*SUM_W +: SUM_W];

  dir_argmax #(
    .NUM_DIR (NUM_DIR),
    .SUM_W   (SUM_W),
    .DIR_W   (DIR_W)
  ) u_argmax (
    .sums    (sums),
    .exclude (phase_dir),
    .win_idx (arg_idx),
    .win_sum (arg_sum)
  );

`ifdef STARVATION_GUARD_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_cnt [NUM_DIR];
  logic              starved;
  logic [DIR_W-1:0]  starve_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned d = 0; d < NUM_DIR; d++) wait_cnt[d] <= '0;
    end else if (en) begin
      for (int unsigned d = 0; d < NUM_DIR; d++) begin
        if (sums[d*SUM_W +: SUM_W] == '0 || (state == GREEN && phase_dir == DIR_W'(d)))
          wait_cnt[d] <= '0;
        else if (wait_cnt[d] != WAIT_W'(MAX_WAIT))
          wait_cnt[d] <= wait_cnt[d] + 1'b1;
      end
    end
  end

  always_comb begin
    starved    = 1'b0;
    starve_idx = '0;
    for (int unsigned d = 0; d < NUM_DIR; d++) begin
      if (!starved && wait_cnt[d] == WAIT_W'(MAX_WAIT) && phase_dir != DIR_W'(d)) begin
        starved    = 1'b1;
        starve_idx = DIR_W'(d);
      end
    end
  end

  assign cand_idx  = starved ? starve_idx : arg_idx;
  assign do_switch = starved || (arg_sum > cur_sum);
`else
  assign cand_idx  = arg_idx;
  // A zero current sum with a non-zero candidate is covered by '>'.
  assign do_switch = arg_sum > cur_sum;
`endif

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    next_dir_n = next_dir;
    dir_n      = phase_dir;
    pc_n       = 1'b0;
    unique case (state)
      GREEN: begin
        // Timer saturates, so every cycle after the minimum is a decision point.
        if (timer == TMR_W'(MIN_GREEN - 1)) begin
          if (do_switch) begin
            state_n    = YELLOW;
            timer_n    = '0;
            next_dir_n = cand_idx;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      YELLOW: begin
        if (timer == TMR_W'(YELLOW_CYC - 1)) begin
          state_n = ALLRED;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ALLRED: begin
        state_n = GREEN;
        timer_n = '0;
        dir_n   = next_dir;
        pc_n    = 1'b1;
      end
      default: state_n = GREEN;
    endcase
    // Lights are decoded from the next state so they can be registered.
    green_n  = (state_n == GREEN)  ? (DIR_MASK << (dir_n * LANES_PER_DIR)) : '0;
    yellow_n = (state_n == YELLOW) ? (DIR_MASK << (dir_n * LANES_PER_DIR)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= GREEN;
      timer        <= '0;
      next_dir     <= '0;
      phase_dir    <= '0;
      green        <= DIR_MASK;
      yellow       <= '0;
      phase_change <= 1'b0;
    end else if (en) begin
      state        <= state_n;
      timer        <= timer_n;
      next_dir     <= next_dir_n;
      phase_dir    <= dir_n;
      green        <= green_n;
      yellow       <= yellow_n;
      phase_change <= pc_n;
    end
  end

endmodule

// File: tb/tb_adaptive_phase_controller.sv
// Directed self-checking bench for adaptive_phase_controller (default
// parameters: 4 directions x 2 lanes, MIN_GREEN=8, YELLOW_CYC=3, MAX_WAIT=32).
// Cycle c is the interval after the c-th rising edge following reset release.
// Observed vector layout: {phase_dir[1:0], phase_change, yellow[7:0], green[7:0]}.
module tb_adaptive_phase_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [63:0] lane_count = '0;
  logic [7:0]  green, yellow;
  logic [1:0]  phase_dir;
  logic        phase_change;
  logic [18:0] obs;
  logic [18:0] e;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  assign obs = {phase_dir, phase_change, yellow, green};

  adaptive_phase_controller #(
    .NUM_DIR       (4),
    .LANES_PER_DIR (2),
    .COUNT_W       (8),
    .MIN_GREEN     (8),
    .YELLOW_CYC    (3),
    .MAX_WAIT      (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .lane_count   (lane_count),
    .green        (green),
    .yellow       (yellow),
    .phase_dir    (phase_dir),
    .phase_change (phase_change)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  task automatic set_dir(input int d, input logic [7:0] a, input logic [7:0] b);
    lane_count[(d*2)*8 +: 8]   = a;
    lane_count[(d*2+1)*8 +: 8] = b;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    lane_count = '0;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== {2'd0, 1'b0, 8'h00, 8'h03}) begin
      n_fail++;
      $display("FAIL reset_held got=%h want=%h", obs, {2'd0, 1'b0, 8'h00, 8'h03});
    end
    apply_reset();
    for (int c = 0; c < 30; c++) begin
      if (c > 0) step();
      n_checks++;
      if (obs !== {2'd0, 1'b0, 8'h00, 8'h03}) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d got=%h want=%h", c, obs, {2'd0, 1'b0, 8'h00, 8'h03});
      end
    end
  endtask

  task automatic test_basic_switch();
    lane_count = '0;
    set_dir(2, 8'd5, 8'd5);
    apply_reset();
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) step();
      if (c <= 7)       e = {2'd0, 1'b0, 8'h00, 8'h03};
      else if (c <= 10) e = {2'd0, 1'b0, 8'h03, 8'h00};
      else if (c == 11) e = {2'd0, 1'b0, 8'h00, 8'h00};
      else              e = {2'd2, (c == 12), 8'h00, 8'h30};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL basic_switch c=%0d got=%h want=%h", c, obs, e);
      end
    end
  endtask

  task automatic test_tie_break();
    lane_count = '0;
    set_dir(0, 8'd5, 8'd5);
    set_dir(1, 8'd5, 8'd5);
    set_dir(3, 8'd5, 8'd5);
    apply_reset();
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) step();
      n_checks++;
      if (obs !== {2'd0, 1'b0, 8'h00, 8'h03}) begin
        n_fail++;
        $display("FAIL equal_sums c=%0d got=%h want=%h", c, obs, {2'd0, 1'b0, 8'h00, 8'h03});
      end
    end
    set_dir(1, 8'd5, 8'd6);
    set_dir(3, 8'd6, 8'd5);
    for (int c = 21; c <= 26; c++) begin
      step();
      if (c <= 23)      e = {2'd0, 1'b0, 8'h03, 8'h00};
      else if (c == 24) e = {2'd0, 1'b0, 8'h00, 8'h00};
      else              e = {2'd1, (c == 25), 8'h00, 8'h0C};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL tie_break c=%0d got=%h want=%h", c, obs, e);
      end
    end
  endtask

  task automatic test_en_freeze();
    lane_count = '0;
    set_dir(2, 8'd5, 8'd5);
    apply_reset();
    for (int c = 1; c <= 9; c++) step();
    n_checks++;
    if (obs !== {2'd0, 1'b0, 8'h03, 8'h00}) begin
      n_fail++;
      $display("FAIL freeze_pre got=%h want=%h", obs, {2'd0, 1'b0, 8'h03, 8'h00});
    end
    en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++;
      if (obs !== {2'd0, 1'b0, 8'h03, 8'h00}) begin
        n_fail++;
        $display("FAIL freeze_hold k=%0d got=%h want=%h", k, obs, {2'd0, 1'b0, 8'h03, 8'h00});
      end
    end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 0)      e = {2'd0, 1'b0, 8'h03, 8'h00};
      else if (k == 1) e = {2'd0, 1'b0, 8'h00, 8'h00};
      else             e = {2'd2, 1'b1, 8'h00, 8'h30};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL freeze_resume k=%0d got=%h want=%h", k, obs, e);
      end
    end
    en = 1'b0;
    step();
    n_checks++;
    if (obs !== {2'd2, 1'b1, 8'h00, 8'h30}) begin
      n_fail++;
      $display("FAIL pulse_held got=%h want=%h", obs, {2'd2, 1'b1, 8'h00, 8'h30});
    end
    en = 1'b1;
    step();
    n_checks++;
    if (obs !== {2'd2, 1'b0, 8'h00, 8'h30}) begin
      n_fail++;
      $display("FAIL pulse_end got=%h want=%h", obs, {2'd2, 1'b0, 8'h00, 8'h30});
    end
  endtask

  task automatic test_async_reset();
    for (int t = 0; t < 2; t++) begin
      lane_count = '0;
      set_dir(2, 8'd5, 8'd5);
      apply_reset();
      for (int c = 1; c <= ((t == 0) ? 9 : 11); c++) step();
      e = (t == 0) ? {2'd0, 1'b0, 8'h03, 8'h00} : {2'd0, 1'b0, 8'h00, 8'h00};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL async_pre t=%0d got=%h want=%h", t, obs, e);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs !== {2'd0, 1'b0, 8'h00, 8'h03}) begin
        n_fail++;
        $display("FAIL async_reset t=%0d got=%h want=%h", t, obs, {2'd0, 1'b0, 8'h00, 8'h03});
      end
    end
  endtask

  task automatic test_starvation();
    lane_count = '0;
    set_dir(0, 8'd100, 8'd100);
    set_dir(1, 8'd1, 8'd0);
    set_dir(3, 8'd0, 8'd1);
    apply_reset();
`ifdef STARVATION_GUARD_EN
    for (int c = 0; c <= 37; c++) begin
      if (c > 0) step();
      if (c <= 32)      e = {2'd0, 1'b0, 8'h00, 8'h03};
      else if (c <= 35) e = {2'd0, 1'b0, 8'h03, 8'h00};
      else if (c == 36) e = {2'd0, 1'b0, 8'h00, 8'h00};
      else              e = {2'd1, 1'b1, 8'h00, 8'h0C};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL starvation c=%0d got=%h want=%h", c, obs, e);
      end
    end
`else
    for (int c = 0; c <= 60; c++) begin
      if (c > 0) step();
      n_checks++;
      if (obs !== {2'd0, 1'b0, 8'h00, 8'h03}) begin
        n_fail++;
        $display("FAIL no_starve_guard c=%0d got=%h want=%h", c, obs, {2'd0, 1'b0, 8'h00, 8'h03});
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_switch();
    test_tie_break();
    test_en_freeze();
    test_async_reset();
    test_starvation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
